// File: rtl/systolic_tile_ctrl_pkg.sv
// Shared types for the systolic tile controller.
//   scalar_t      : one array lane input, {data, valid}
//   tile_state_e  : tile sequencer states
//   DRAIN_CYC     : cycles held after the last operand read for the default array size
package systolic_tile_ctrl_pkg;

  localparam int SYS_ARRAY_LEN = 4;
  localparam int SINGLE_W      = 32;

  typedef struct packed {
    logic [SINGLE_W-1:0] data;
    logic                valid;
  } scalar_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } tile_state_e;

  // Drain covers 1 read latency + (n-1) skew + (n-1) array propagation, plus one cycle of slack.
  function automatic int drain_cyc(input int n);
    return 2 * n;
  endfunction

  localparam int DRAIN_CYC = drain_cyc(SYS_ARRAY_LEN);

endpackage

// File: rtl/systolic_tile_ctrl_skew_line.sv
// Fixed-depth delay line for one array lane.
//   clk, rst : clock, asynchronous active-high reset
//   flush    : synchronous clear of every stage to {0,0}
//   in, out  : scalar_t payload; depth D=0 is a straight wire
module systolic_tile_ctrl_skew_line
  import systolic_tile_ctrl_pkg::*;
#(
  parameter int D = 0
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    flush,
  input  scalar_t in,
  output scalar_t out
);

  generate
    if (D == 0) begin : g_pass
      logic w_unused;
      assign w_unused = clk ^ rst ^ flush;
      assign out      = in;
    end else begin : g_delay
      scalar_t r_sr [D];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < D; s++) r_sr[s] <= '0;
        end else if (flush) begin
          for (int s = 0; s < D; s++) r_sr[s] <= '0;
        end else begin
          r_sr[0] <= in;
          for (int s = 1; s < D; s++) r_sr[s] <= r_sr[s-1];
        end
      end

      assign out = r_sr[D-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_tile_ctrl.sv
// Sequencer for one output-stationary matrix-multiply tile.
//   start/k_len   : request a tile of inner dimension K (sampled on acceptance)
//   abort         : cancel the running tile, back to IDLE without done
//   busy/done     : status; done is a 1-cycle pulse when the array result is valid
//   rd_en/rd_addr : operand-buffer read; a_vec/b_vec return one cycle later
//   arr_clear     : 1-cycle accumulator clear at tile start
//   row/column    : skewed lane inputs to the array (row from A, column from B)
module systolic_tile_ctrl
  import systolic_tile_ctrl_pkg::*;
#(
  parameter int N  = SYS_ARRAY_LEN,
  parameter int KW = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [KW-1:0]                k_len,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  output logic                         rd_en,
  output logic [KW-1:0]                rd_addr,
  input  logic [N-1:0][SINGLE_W-1:0]   a_vec,
  input  logic [N-1:0][SINGLE_W-1:0]   b_vec,
  output logic                         arr_clear,
  output scalar_t [N-1:0]              column,
  output scalar_t [N-1:0]              row
);

  localparam int DRAIN_N = drain_cyc(N);
  localparam int DCW     = $clog2(DRAIN_N + 1);

  tile_state_e    r_state;
  tile_state_e    w_state_nxt;
  logic [KW-1:0]  r_k;
  logic [KW-1:0]  r_cnt;
  logic [DCW-1:0] r_dcnt;
  logic           r_rd_p1;
  logic           w_k_load;
  logic           w_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_load    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    arr_clear   = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = S_CLEAR;
          w_k_load    = 1'b1;
        end
      end
      S_CLEAR: begin
        arr_clear   = 1'b1;
        w_state_nxt = (r_k == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        rd_en   = 1'b1;
        rd_addr = r_cnt;
        if (r_cnt == r_k - 1'b1) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_dcnt == DCW'(DRAIN_N - 1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        // A start coincident with done is taken directly, since DONE is not IDLE.
        if (start) begin
          w_state_nxt = S_CLEAR;
          w_k_load    = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort overrides everything outside IDLE, including a start seen in DONE.
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_k_load    = 1'b0;
    end
  end

  assign w_flush = abort && (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k     <= '0;
      r_cnt   <= '0;
      r_dcnt  <= '0;
      r_rd_p1 <= 1'b0;
    end else begin
      if (w_k_load) r_k <= k_len;
      r_cnt   <= (rd_en && (w_state_nxt == S_FEED)) ? r_cnt + 1'b1 : '0;
      r_dcnt  <= (r_state == S_DRAIN) ? r_dcnt + 1'b1 : '0;
      r_rd_p1 <= rd_en && !w_flush;
    end
  end

  // ---- p1: operand data returns one cycle after rd_en and enters the lane skew lines ----
  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      scalar_t w_row_in;
      scalar_t w_col_in;

      // Data is masked so idle lane positions present {0,0} rather than buffer garbage.
      assign w_row_in = {({SINGLE_W{r_rd_p1}} & a_vec[i]), r_rd_p1};
      assign w_col_in = {({SINGLE_W{r_rd_p1}} & b_vec[i]), r_rd_p1};

      systolic_tile_ctrl_skew_line #(.D(i)) u_row_skew (
        .clk   (clk),
        .rst   (rst),
        .flush (w_flush),
        .in    (w_row_in),
        .out   (row[i])
      );

      systolic_tile_ctrl_skew_line #(.D(i)) u_col_skew (
        .clk   (clk),
        .rst   (rst),
        .flush (w_flush),
        .in    (w_col_in),
        .out   (column[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Self-checking bench for systolic_tile_ctrl: directed scenarios followed by
// randomized start/abort traffic, compared cycle by cycle against a tile timeline model.
module tb_systolic_tile_ctrl;
  import systolic_tile_ctrl_pkg::*;

  localparam int N    = SYS_ARRAY_LEN;
  localparam int KW   = 8;
  localparam int SW   = SINGLE_W;
  localparam int KMAX = 16;

  logic                     clk   = 1'b0;
  logic                     rst   = 1'b1;
  logic                     start = 1'b0;
  logic                     abort = 1'b0;
  logic [KW-1:0]            k_len = '0;
  logic [N-1:0][SW-1:0]     a_vec = '0;
  logic [N-1:0][SW-1:0]     b_vec = '0;
  logic                     busy, done, rd_en, arr_clear;
  logic [KW-1:0]            rd_addr;
  scalar_t [N-1:0]          column, row;

  always #5 clk = ~clk;

  systolic_tile_ctrl #(.N(N), .KW(KW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .a_vec     (a_vec),
    .b_vec     (b_vec),
    .arr_clear (arr_clear),
    .column    (column),
    .row       (row)
  );

  int n_tests   = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int done_seen = 0;

  // Tile timeline model: tile accepted at cycle t0 with K=kk; cycles after t0+cut are idle.
  int t0  = -1000;
  int kk  = 0;
  int cut = 1 << 30;
  logic [SW-1:0] amem [KMAX][N];
  logic [SW-1:0] bmem [KMAX][N];
  logic          prev_rd   = 1'b0;
  logic [KW-1:0] prev_addr = '0;

  function automatic int last_rel();
    return (kk == 0) ? 2 : kk + 2 + 2 * N;
  endfunction

  function automatic bit m_active(input int c);
    int r;
    r = c - t0;
    return (r >= 1) && (r <= last_rel()) && (r <= cut);
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int r;
    int k;
    bit act;
    bit e_rd;
    scalar_t [N-1:0] e_row;
    scalar_t [N-1:0] e_col;
    r    = cyc - t0;
    act  = m_active(cyc);
    e_rd = act && (kk > 0) && (r >= 2) && (r <= kk + 1);
    chk("busy", busy, act);
    chk("done", done, act && (r == last_rel()));
    chk("arr_clear", arr_clear, act && (r == 1));
    chk("rd_en", rd_en, e_rd);
    if (e_rd) chk("rd_addr", rd_addr, r - 2);
    for (int i = 0; i < N; i++) begin
      k = r - 3 - i;
      if ((r <= cut) && (k >= 0) && (k < kk)) begin
        e_row[i] = {amem[k][i], 1'b1};
        e_col[i] = {bmem[k][i], 1'b1};
      end else begin
        e_row[i] = '0;
        e_col[i] = '0;
      end
    end
    chk("row", row, e_row);
    chk("column", column, e_col);
  endtask

  // One clock: the operand buffer answers the previous cycle's read, then outputs are checked.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++) begin
      a_vec[i] = prev_rd ? amem[prev_addr][i] : SW'($urandom());
      b_vec[i] = prev_rd ? bmem[prev_addr][i] : SW'($urandom());
    end
    #1;
    check_outputs();
    if (done) done_seen++;
    prev_rd   = rd_en;
    prev_addr = rd_addr;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input bit s, input bit a, input int k);
    start = s;
    abort = a;
    k_len = KW'(k);
    if (a && m_active(cyc)) begin
      cut = cyc - t0;
    end else if (s && (!m_active(cyc) || ((cyc - t0) == last_rel()))) begin
      t0  = cyc;
      kk  = k;
      cut = 1 << 30;
      for (int kx = 0; kx < KMAX; kx++)
        for (int i = 0; i < N; i++) begin
          amem[kx][i] = SW'($urandom());
          bmem[kx][i] = SW'($urandom());
        end
    end
  endtask

  int d0;

  initial begin
    for (int kx = 0; kx < KMAX; kx++)
      for (int i = 0; i < N; i++) begin
        amem[kx][i] = '0;
        bmem[kx][i] = '0;
      end
    #3;
    check_outputs();
    chk("rd_addr_rst", rd_addr, 0);
    run(2);
    rst = 1'b0;
    run(2);

    // K=1
    drive(1, 0, 1); tick(); drive(0, 0, 0); run(last_rel() + 2);

    // K=3 with a second start during FEED, which must be ignored
    d0 = done_seen;
    drive(1, 0, 3); tick(); drive(0, 0, 0); run(3);
    drive(1, 0, 5); tick(); drive(0, 0, 0); run(20);
    chk("one_done", done_seen - d0, 1);

    // K=0
    drive(1, 0, 0); tick(); drive(0, 0, 0); run(4);

    // abort in the second FEED cycle
    drive(1, 0, 4); tick(); drive(0, 0, 0); tick(); tick();
    d0 = done_seen;
    drive(0, 1, 0); tick(); drive(0, 0, 0); run(20);
    chk("abort_no_done", done_seen - d0, 0);

    // a fresh tile after the abort
    drive(1, 0, $urandom_range(1, 6)); tick(); drive(0, 0, 0); run(last_rel() + 2);

    // start coincident with done
    drive(1, 0, 2); tick(); drive(0, 0, 0);
    while (cyc < t0 + last_rel()) tick();
    drive(1, 0, 3); tick(); drive(0, 0, 0); run(last_rel() + 2);

    // start and abort together in IDLE: start wins
    drive(1, 1, 2); tick(); drive(0, 0, 0); run(last_rel() + 2);

    // asynchronous reset in the middle of DRAIN, off the clock edge
    drive(1, 0, 2); tick(); drive(0, 0, 0); run(5);
    #3 rst = 1'b1;
    #1;
    t0 = -1000; kk = 0; cut = 1 << 30;
    check_outputs();
    prev_rd = 1'b0;
    tick();
    rst = 1'b0;
    run(2);
    drive(1, 0, 3); tick(); drive(0, 0, 0); run(last_rel() + 2);

    // randomized start/abort traffic
    repeat (400) begin
      drive(($urandom % 6) == 0, ($urandom % 20) == 0, $urandom_range(0, 6));
      tick();
    end
    drive(0, 0, 0);
    run(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
